// File: rtl/cell_stream_pkg.sv
// Shared types and constants for the cell stream arbiter.
package cell_stream_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned PKT_WORDS = 4;
   localparam int unsigned BEAT_W    = 2;
   localparam int unsigned TID_W     = 3;
   localparam int unsigned MAX_PORTS = 1 << TID_W;

   // Beat order on the link
   localparam logic [BEAT_W-1:0] HDR = 2'd0;
   localparam logic [BEAT_W-1:0] DX  = 2'd1;
   localparam logic [BEAT_W-1:0] DY  = 2'd2;
   localparam logic [BEAT_W-1:0] DS  = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // One captured packet, header first
   typedef struct packed {
      logic [WORD_W-1:0] hdr;
      logic [WORD_W-1:0] dx;
      logic [WORD_W-1:0] dy;
      logic [WORD_W-1:0] ds;
   } pkt_t;

   // Word of a packet presented on a given beat
   function automatic logic [WORD_W-1:0] pkt_word(input pkt_t p, input logic [BEAT_W-1:0] b);
      case (b)
         HDR:     return p.hdr;
         DX:      return p.dx;
         DY:      return p.dy;
         default: return p.ds;
      endcase
   endfunction

endpackage

// File: rtl/cell_stream_rr_pick.sv
// Rotating-priority picker: first requester after last_grant, wrapping at NPORTS.
module cell_stream_rr_pick
   import cell_stream_pkg::*;
#(
   parameter int unsigned NPORTS = 4
) (
   input  logic [NPORTS-1:0] req,
   input  logic [TID_W-1:0]  last_grant,
   output logic              gnt_valid,
   output logic [TID_W-1:0]  gnt_idx
);

   localparam int unsigned SUM_W = TID_W + 1;

   logic [MAX_PORTS-1:0] req_pad;
   logic [SUM_W-1:0]     sum;
   logic [TID_W-1:0]     cand;

   assign req_pad = MAX_PORTS'(req);

   // Scan from farthest to nearest so the nearest requester after last_grant wins
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      cand      = '0;
      for (int i = int'(NPORTS); i > 0; i--) begin
         sum = SUM_W'(last_grant) + SUM_W'(i);
         if (sum >= SUM_W'(NPORTS)) sum = sum - SUM_W'(NPORTS);
         cand = sum[TID_W-1:0];
         if (req_pad[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/cell_stream_arbiter.sv
// Round-robin serializer of per-port 4-word packets onto one AXI-stream link.
module cell_stream_arbiter
   import cell_stream_pkg::*;
#(
   parameter int unsigned NPORTS = 4,
   parameter int unsigned CW     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NPORTS-1:0]        stream_mux_strobe,
   input  logic [NPORTS*32-1:0]     stream_in_header,
   input  logic [NPORTS*32-1:0]     stream_in_datax,
   input  logic [NPORTS*32-1:0]     stream_in_datay,
   input  logic [NPORTS*32-1:0]     stream_in_datas,
   output logic                     tvalid,
   input  logic                     tready,
   output logic                     tlast,
   output logic [31:0]              tdata,
   output logic [2:0]               tid,
   output logic [NPORTS-1:0]        pending,
   output logic                     busy,
   output logic [NPORTS*CW-1:0]     overflow_cnt
);

   state_t                      state_q, state_d;
   logic [NPORTS-1:0]           pending_q;
   pkt_t                        hold_q [NPORTS];
   pkt_t                        obuf_q;
   logic [BEAT_W-1:0]           optr_q;
   logic [TID_W-1:0]            last_grant_q;
   logic [NPORTS-1:0][CW-1:0]   ovf_q;
   logic                        tvalid_q, tlast_q;
   logic [WORD_W-1:0]           tdata_q;
   logic [TID_W-1:0]            tid_q;

   logic [NPORTS-1:0]           req_c;
   logic                        gnt_valid_c;
   logic [TID_W-1:0]            gnt_idx_c;
   logic                        xfer_c, last_xfer_c, grant_c;
   logic [NPORTS-1:0]           grant_oh_c;
   pkt_t                        sel_pkt_c;
   logic [BEAT_W-1:0]           nxt_ptr_c;

   assign req_c       = enable ? pending_q : '0;
   assign xfer_c      = tvalid_q & tready;
   assign last_xfer_c = xfer_c & (optr_q == DS);
   assign grant_c     = gnt_valid_c & ((state_q == IDLE) | last_xfer_c);
   assign nxt_ptr_c   = optr_q + BEAT_W'(1);

   cell_stream_rr_pick #(.NPORTS(NPORTS)) u_pick (
      .req        (req_c),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid_c),
      .gnt_idx    (gnt_idx_c)
   );

   // One-hot grant and the holding register it selects
   always_comb begin
      grant_oh_c = '0;
      sel_pkt_c  = '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
         if (grant_c && (gnt_idx_c == TID_W'(p))) begin
            grant_oh_c[p] = 1'b1;
            sel_pkt_c     = hold_q[p];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: stay in SEND across back-to-back grants
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_c) state_d = SEND;
         SEND:    if (last_xfer_c && !grant_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-port capture into holding registers; drops counted when the slot is occupied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         ovf_q     <= '0;
         for (int p = 0; p < int'(NPORTS); p++) hold_q[p] <= '0;
      end else begin
         for (int p = 0; p < int'(NPORTS); p++) begin
            if (stream_mux_strobe[p]) begin
               if (!pending_q[p] || grant_oh_c[p]) begin
                  hold_q[p] <= '{hdr: stream_in_header[WORD_W*p +: WORD_W],
                                 dx:  stream_in_datax[WORD_W*p +: WORD_W],
                                 dy:  stream_in_datay[WORD_W*p +: WORD_W],
                                 ds:  stream_in_datas[WORD_W*p +: WORD_W]};
                  pending_q[p] <= 1'b1;
               end else if (ovf_q[p] != {CW{1'b1}}) begin
                  ovf_q[p] <= ovf_q[p] + CW'(1);
               end
            end else if (grant_oh_c[p]) begin
               pending_q[p] <= 1'b0;
            end
         end
      end
   end

   // Output buffer and registered stream outputs; held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obuf_q       <= '0;
         optr_q       <= HDR;
         last_grant_q <= TID_W'(NPORTS - 1);
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         tdata_q      <= '0;
         tid_q        <= '0;
      end else if (grant_c) begin
         obuf_q       <= sel_pkt_c;
         optr_q       <= HDR;
         last_grant_q <= gnt_idx_c;
         tvalid_q     <= 1'b1;
         tlast_q      <= 1'b0;
         tdata_q      <= sel_pkt_c.hdr;
         tid_q        <= gnt_idx_c;
      end else if (last_xfer_c) begin
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
      end else if (xfer_c) begin
         optr_q       <= nxt_ptr_c;
         tdata_q      <= pkt_word(obuf_q, nxt_ptr_c);
         tlast_q      <= (nxt_ptr_c == DS);
      end
   end

   assign tvalid       = tvalid_q;
   assign tlast        = tlast_q;
   assign tdata        = tdata_q;
   assign tid          = tid_q;
   assign pending      = pending_q;
   assign busy         = (state_q == SEND);
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_cell_stream_arbiter.sv
// Scoreboard bench for cell_stream_arbiter: directed stimulus, expected beats queued, monitor compares.
module tb_cell_stream_arbiter;

   localparam int unsigned NP = 4;
   localparam int unsigned CW = 4;

   logic              clk = 1'b0;
   logic              rst_n, enable, tready;
   logic [NP-1:0]     strobe;
   logic [NP*32-1:0]  hdr, dx, dy, ds;
   logic              tvalid, tlast, busy;
   logic [31:0]       tdata;
   logic [2:0]        tid;
   logic [NP-1:0]     pending;
   logic [NP*CW-1:0]  ovf;

   typedef struct packed {
      logic [31:0] d;
      logic        last;
      logic [2:0]  id;
   } beat_t;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    beats_seen = 0;
   logic  prev_stall = 1'b0;
   beat_t prev_b;

   always #5 clk = ~clk;

   cell_stream_arbiter #(.NPORTS(NP), .CW(CW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .stream_mux_strobe (strobe),
      .stream_in_header  (hdr),
      .stream_in_datax   (dx),
      .stream_in_datay   (dy),
      .stream_in_datas   (ds),
      .tvalid            (tvalid),
      .tready            (tready),
      .tlast             (tlast),
      .tdata             (tdata),
      .tid               (tid),
      .pending           (pending),
      .busy              (busy),
      .overflow_cnt      (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [31:0] h, x, y, s);
      hdr[32*p +: 32] = h;
      dx[32*p +: 32]  = x;
      dy[32*p +: 32]  = y;
      ds[32*p +: 32]  = s;
   endtask

   task automatic push_pkt(input logic [2:0] id, input logic [31:0] h, x, y, s);
      exp_q.push_back('{d: h, last: 1'b0, id: id});
      exp_q.push_back('{d: x, last: 1'b0, id: id});
      exp_q.push_back('{d: y, last: 1'b0, id: id});
      exp_q.push_back('{d: s, last: 1'b1, id: id});
   endtask

   // Called in the post-edge phase; strobe is captured on the next rising edge
   task automatic pulse(input logic [NP-1:0] m);
      strobe = m;
      tick();
      strobe = '0;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || tvalid) && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || tvalid) begin
         errors++;
         $display("FAIL drain: beats_left=%0d tvalid=%0b expected 0 and 0", exp_q.size(), tvalid);
      end
   endtask

   // Monitor: compare every handshaken beat and verify stability across stalls
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_tvalid", 32'(tvalid), 32'd1);
            check("stall_tdata",  tdata, prev_b.d);
            check("stall_tlast",  32'(tlast), 32'(prev_b.last));
            check("stall_tid",    32'(tid), 32'(prev_b.id));
         end
         if (tvalid && tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got tdata=0x%08h tid=%0d expected no beat", tdata, tid);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_tdata", tdata, e.d);
               check("beat_tlast", 32'(tlast), 32'(e.last));
               check("beat_tid",   32'(tid), 32'(e.id));
            end
         end
         prev_stall = tvalid && !tready;
         prev_b     = '{d: tdata, last: tlast, id: tid};
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0; enable = 1'b1; tready = 1'b0; strobe = '0;
      hdr = '0; dx = '0; dy = '0; ds = '0;
      #2;
      check("rst_tvalid",  32'(tvalid), 32'd0);
      check("rst_tlast",   32'(tlast), 32'd0);
      check("rst_tdata",   tdata, 32'd0);
      check("rst_tid",     32'(tid), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_ovf",     32'(ovf), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single packet on port 1 with latency check
      tready = 1'b1;
      set_port(1, 32'hA0000001, 32'h11, 32'h22, 32'h33);
      push_pkt(3'd1, 32'hA0000001, 32'h11, 32'h22, 32'h33);
      pulse(4'b0010);
      @(negedge clk);
      check("lat_n1_tvalid",  32'(tvalid), 32'd0);
      check("lat_n1_pending", 32'(pending), 32'h2);
      @(negedge clk);
      check("lat_n2_tvalid", 32'(tvalid), 32'd1);
      check("lat_n2_busy",   32'(busy), 32'd1);
      tick();
      drain(20);
      check("single_pending", 32'(pending), 32'd0);

      // Round robin 0,2,3 with no bubbles
      do_reset();
      tready = 1'b1;
      set_port(0, 32'hB0000000, 32'h100, 32'h101, 32'h102);
      set_port(2, 32'hB0000002, 32'h200, 32'h201, 32'h202);
      set_port(3, 32'hB0000003, 32'h300, 32'h301, 32'h302);
      push_pkt(3'd0, 32'hB0000000, 32'h100, 32'h101, 32'h102);
      push_pkt(3'd2, 32'hB0000002, 32'h200, 32'h201, 32'h202);
      push_pkt(3'd3, 32'hB0000003, 32'h300, 32'h301, 32'h302);
      pulse(4'b1101);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("rr_no_bubble", 32'(tvalid), 32'd1);
      end
      @(negedge clk);
      check("rr_end_tvalid", 32'(tvalid), 32'd0);
      check("rr_pending",    32'(pending), 32'd0);
      tick();
      drain(10);

      // Backpressure: tready 1,0,0,1
      do_reset();
      tready = 1'b0;
      set_port(3, 32'hC0000003, 32'h31, 32'h32, 32'h33);
      push_pkt(3'd3, 32'hC0000003, 32'h31, 32'h32, 32'h33);
      base = beats_seen;
      pulse(4'b1000);
      tick();
      tready = 1'b1; tick();
      tready = 1'b0; tick(); tick();
      tready = 1'b1;
      drain(20);
      check("bp_beat_count", 32'(beats_seen - base), 32'd4);

      // Overflow: grant, capture, drop, then saturate
      do_reset();
      tready = 1'b0;
      set_port(0, 32'hD0000001, 32'h1, 32'h2, 32'h3);
      push_pkt(3'd0, 32'hD0000001, 32'h1, 32'h2, 32'h3);
      pulse(4'b0001);
      set_port(0, 32'hD0000002, 32'h4, 32'h5, 32'h6);
      push_pkt(3'd0, 32'hD0000002, 32'h4, 32'h5, 32'h6);
      pulse(4'b0001);
      set_port(0, 32'hD0000003, 32'h7, 32'h8, 32'h9);
      pulse(4'b0001);
      check("ovf_one",      32'(ovf[CW-1:0]), 32'd1);
      check("ovf_pending0", 32'(pending), 32'h1);
      for (int i = 0; i < 14; i++) pulse(4'b0001);
      check("ovf_max", 32'(ovf[CW-1:0]), 32'd15);
      pulse(4'b0001);
      check("ovf_sat", 32'(ovf[CW-1:0]), 32'd15);
      tready = 1'b1;
      drain(30);
      check("ovf_pending_end", 32'(pending), 32'd0);

      // Same-cycle grant and capture on port 2
      set_port(2, 32'hE0000002, 32'h51, 32'h52, 32'h53);
      push_pkt(3'd2, 32'hE0000002, 32'h51, 32'h52, 32'h53);
      pulse(4'b0100);
      set_port(2, 32'hE1000002, 32'h61, 32'h62, 32'h63);
      push_pkt(3'd2, 32'hE1000002, 32'h61, 32'h62, 32'h63);
      pulse(4'b0100);
      check("sc_pending2", 32'(pending), 32'h4);
      check("sc_ovf2",     32'(ovf[2*CW +: CW]), 32'd0);
      drain(30);
      check("sc_pending_end", 32'(pending), 32'd0);

      // Reset while beat 2 is on the link
      set_port(1, 32'hF0000001, 32'h41, 32'h42, 32'h43);
      exp_q.push_back('{d: 32'hF0000001, last: 1'b0, id: 3'd1});
      exp_q.push_back('{d: 32'h41, last: 1'b0, id: 3'd1});
      pulse(4'b0010);
      tick(); tick(); tick();
      check("mid_beat2_tdata", tdata, 32'h42);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid",  32'(tvalid), 32'd0);
      check("mid_rst_busy",    32'(busy), 32'd0);
      check("mid_rst_tdata",   tdata, 32'd0);
      check("mid_rst_pending", 32'(pending), 32'd0);
      check("mid_rst_ovf",     32'(ovf), 32'd0);
      check("mid_rst_q",       32'(exp_q.size()), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // enable=0 mid-packet: finish, then hold with ports 1 and 2 pending
      tready = 1'b1;
      set_port(0, 32'h90000000, 32'h70, 32'h71, 32'h72);
      set_port(1, 32'h90000001, 32'h80, 32'h81, 32'h82);
      set_port(2, 32'h90000002, 32'h90, 32'h91, 32'h92);
      push_pkt(3'd0, 32'h90000000, 32'h70, 32'h71, 32'h72);
      pulse(4'b0111);
      tick();
      enable = 1'b0;
      repeat (8) tick();
      check("en_tvalid",  32'(tvalid), 32'd0);
      check("en_busy",    32'(busy), 32'd0);
      check("en_pending", 32'(pending), 32'h6);
      check("en_q",       32'(exp_q.size()), 32'd0);
      push_pkt(3'd1, 32'h90000001, 32'h80, 32'h81, 32'h82);
      push_pkt(3'd2, 32'h90000002, 32'h90, 32'h91, 32'h92);
      enable = 1'b1;
      drain(30);
      check("en_pending_end", 32'(pending), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
